mips_prog_harness: RTL and testbench

MIPS_PROG_HARNESS -- requirements
Module: mips_prog_harness

---
 rtl/mips_prog_harness.sv | 191 +++++++++++++++++++
 tb/tb_mips_prog_harness.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_prog_harness.sv
// mips_prog_harness: load/run/check sequencer for a MIPS core under test.
//
// Sequence: IDLE -> CLEAR -> LOAD -> RUN -> READ -> CHECK -> IDLE.
//   IDLE  : wait for start; latch the result address and the golden value
//   CLEAR : zero every memory word, one word per cycle
//   LOAD  : accept image words (valid/ready) and write them straight through
//   RUN   : release cpu_rst and count cycles until halt or TIMEOUT
//   READ  : present chk_addr to the memory
//   CHECK : compare the returned word with the golden value, pulse done
//
// Build option: define MIPS_HARNESS_CLEAR_EN to include the CLEAR state and its
// address counter. Without it, start goes straight to LOAD and words that are
// not part of the image keep whatever they held before.
//
// Ports
//   clk1, reset                 sole clock, synchronous active-high reset
//   start                       begin a sequence (only honoured in IDLE)
//   load_valid/ready/addr/data/last   image stream, load_last marks the final word
//   chk_addr, chk_expected      result word address and golden value
//   mem_we/addr/wdata, mem_rdata      single-port memory, read data one cycle late
//   cpu_rst, cpu_halted         processor reset control and halt flag
//   busy, done, pass, timed_out, cycles   status; done is a one-cycle pulse
module mips_prog_harness #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 10,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 2000
) (
  input  logic              clk1,
  input  logic              reset,
  input  logic              start,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic [ADDR_W-1:0] chk_addr,
  input  logic [DATA_W-1:0] chk_expected,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_rst,
  input  logic              cpu_halted,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timed_out,
  output logic [CNT_W-1:0]  cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef MIPS_HARNESS_CLEAR_EN
    S_CLEAR,
`endif
    S_LOAD,
    S_RUN,
    S_READ,
    S_CHECK
  } state_e;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] chk_addr_q, chk_addr_d;
  logic [DATA_W-1:0] chk_exp_q, chk_exp_d;
  logic              pass_q, pass_d;
  logic              timed_out_q, timed_out_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  cycles_q, cycles_d;
  logic [CNT_W-1:0]  cycles_inc;
`ifdef MIPS_HARNESS_CLEAR_EN
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
`endif

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  assign cycles_inc = (&cycles_q) ? cycles_q : cycles_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    chk_addr_d  = chk_addr_q;
    chk_exp_d   = chk_exp_q;
    pass_d      = pass_q;
    timed_out_d = timed_out_q;
    cycles_d    = cycles_q;
    done_d      = 1'b0;
`ifdef MIPS_HARNESS_CLEAR_EN
    clr_cnt_d   = clr_cnt_q;
`endif
    load_ready  = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          chk_addr_d  = chk_addr;
          chk_exp_d   = chk_expected;
          pass_d      = 1'b0;
          timed_out_d = 1'b0;
          cycles_d    = '0;
`ifdef MIPS_HARNESS_CLEAR_EN
          clr_cnt_d   = '0;
          state_d     = S_CLEAR;
`else
          state_d     = S_LOAD;
`endif
        end
      end
`ifdef MIPS_HARNESS_CLEAR_EN
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = clr_cnt_q;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (&clr_cnt_q) state_d = S_LOAD;
      end
`endif
      S_LOAD: begin
        load_ready = 1'b1;
        if (load_valid) begin
          mem_we    = 1'b1;
          mem_addr  = load_addr;
          mem_wdata = load_data;
          if (load_last) state_d = S_RUN;
        end
      end
      S_RUN: begin
        // A halt seen in the same cycle the count would hit TIMEOUT wins.
        if (cpu_halted) begin
          state_d = S_READ;
        end else begin
          cycles_d = cycles_inc;
          if (cycles_inc == TIMEOUT_C) begin
            timed_out_d = 1'b1;
            pass_d      = 1'b0;
            done_d      = 1'b1;
            state_d     = S_IDLE;
          end
        end
      end
      S_READ: begin
        mem_addr = chk_addr_q;
        state_d  = S_CHECK;
      end
      S_CHECK: begin
        mem_addr = chk_addr_q;
        pass_d   = (mem_rdata == chk_exp_q);
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (reset) begin
      state_q     <= S_IDLE;
      chk_addr_q  <= '0;
      chk_exp_q   <= '0;
      pass_q      <= 1'b0;
      timed_out_q <= 1'b0;
      done_q      <= 1'b0;
      cycles_q    <= '0;
`ifdef MIPS_HARNESS_CLEAR_EN
      clr_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      chk_addr_q  <= chk_addr_d;
      chk_exp_q   <= chk_exp_d;
      pass_q      <= pass_d;
      timed_out_q <= timed_out_d;
      done_q      <= done_d;
      cycles_q    <= cycles_d;
`ifdef MIPS_HARNESS_CLEAR_EN
      clr_cnt_q   <= clr_cnt_d;
`endif
    end
  end

  // done is registered so it lines up with the updated pass/timed_out.
  assign cpu_rst   = (state_q != S_RUN);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign pass      = pass_q;
  assign timed_out = timed_out_q;
  assign cycles    = cycles_q;

endmodule

// File: tb/tb_mips_prog_harness.sv
module tb_mips_prog_harness;

   localparam int TO_TB = 50;
`ifdef MIPS_HARNESS_CLEAR_EN
   localparam int          CLR_WORDS = 1024;
   localparam logic [31:0] CLR_VAL   = 32'h0;
`else
   localparam int          CLR_WORDS = 0;
   localparam logic [31:0] CLR_VAL   = 32'hFFFF_FFFF;
`endif

   logic        clk1, reset, start;
   logic        load_valid, load_ready, load_last;
   logic [9:0]  load_addr, chk_addr, mem_addr;
   logic [31:0] load_data, chk_expected, mem_wdata, mem_rdata;
   logic        mem_we, cpu_rst, cpu_halted;
   logic        busy, done, pass, timed_out;
   logic [15:0] cycles;

   mips_prog_harness #(.TIMEOUT(TO_TB)) dut (
      .clk1(clk1), .reset(reset), .start(start),
      .load_valid(load_valid), .load_ready(load_ready), .load_addr(load_addr),
      .load_data(load_data), .load_last(load_last),
      .chk_addr(chk_addr), .chk_expected(chk_expected),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .cpu_rst(cpu_rst), .cpu_halted(cpu_halted),
      .busy(busy), .done(done), .pass(pass), .timed_out(timed_out), .cycles(cycles)
   );

   initial begin
      clk1 = 1'b0;
      forever #5 clk1 = ~clk1;
   end

   typedef struct packed { logic [9:0] a; logic [31:0] d; } wr_t;
   typedef struct packed { logic p; logic t; logic [15:0] c; } res_t;

   wr_t  img[$];
   wr_t  exp_q[$];
   res_t res_q[$];
   int   checks = 0;
   int   errs = 0;
   int   halt_cycle = 100000;

   // Memory plus a tiny MIPS subset interpreter standing in for the core.
   logic [31:0] mem [0:1023];
   int          run_cnt;
   logic        executed;

   task automatic exec_prog();
      logic [31:0] r [0:31];
      logic [31:0] ins, ea;
      int          pc;
      logic        stop;
      for (int k = 0; k < 32; k++) r[k] = 32'h0;
      pc = 0;
      stop = 1'b0;
      for (int s = 0; s < 64; s++) begin
         if (!stop) begin
            ins = mem[pc[9:0]];
            ea  = r[ins[25:21]] + {{16{ins[15]}}, ins[15:0]};
            case (ins[31:26])
               6'h3F: stop = 1'b1;
               6'h08: r[ins[20:16]] = ea;
               6'h00: if (ins[5:0] == 6'h20) r[ins[15:11]] = r[ins[25:21]] + r[ins[20:16]];
               6'h23: r[ins[20:16]] = mem[ea[9:0]];
               6'h2B: mem[ea[9:0]] = r[ins[20:16]];
               default: ;
            endcase
            r[0] = 32'h0;
            pc++;
         end
      end
   endtask

   always @(posedge clk1) begin
      mem_rdata <= mem[mem_addr];
      if (mem_we) mem[mem_addr] = mem_wdata;
      if (cpu_rst) begin
         run_cnt = 0;
         executed = 1'b0;
         cpu_halted <= 1'b0;
      end else begin
         if (!executed) begin
            exec_prog();
            executed = 1'b1;
         end
         run_cnt++;
         cpu_halted <= (run_cnt >= halt_cycle);
      end
   end

   task automatic do_start(input logic [9:0] ca, input logic [31:0] ce);
      int n, bad, g;
      @(negedge clk1);
      start = 1'b1;
      chk_addr = ca;
      chk_expected = ce;
      @(negedge clk1);
      start = 1'b0;
      chk_addr = 10'h3FF;
      chk_expected = 32'hDEAD_BEEF;
      n = 0; bad = 0; g = 0;
      while (load_ready !== 1'b1 && g < 1100) begin
         if (mem_we === 1'b1) begin
            if (mem_addr !== n[9:0] || mem_wdata !== 32'h0) bad++;
            n++;
         end
         @(negedge clk1);
         g++;
      end
      checks++;
      if (n != CLR_WORDS || bad != 0 || load_ready !== 1'b1) begin
         errs++;
         $display("FAIL clear_phase: writes %0d bad %0d ready %b, want writes %0d bad 0 ready 1",
                  n, bad, load_ready, CLR_WORDS);
      end
   endtask

   task automatic load_image();
      int gap, gbad;
      wr_t e;
      gbad = 0;
      for (int i = 0; i < img.size(); i++) begin
         gap = $urandom_range(0, 3);
         for (int k = 0; k < gap; k++) begin
            load_valid = 1'b0;
            #1;
            if (mem_we !== 1'b0 || load_ready !== 1'b1) gbad++;
            @(negedge clk1);
         end
         load_valid = 1'b1;
         load_addr  = img[i].a;
         load_data  = img[i].d;
         load_last  = (i == img.size() - 1);
         exp_q.push_back(img[i]);
         #1;
         e = exp_q.pop_front();
         checks++;
         if (mem_we !== 1'b1 || mem_addr !== e.a || mem_wdata !== e.d) begin
            errs++;
            $display("FAIL load_write[%0d]: we %b addr %0d data %h, want we 1 addr %0d data %h",
                     i, mem_we, mem_addr, mem_wdata, e.a, e.d);
         end
         @(negedge clk1);
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
      checks++;
      if (gbad != 0) begin
         errs++;
         $display("FAIL load_gap: %0d idle cycles with write or no ready, want 0", gbad);
      end
   endtask

   task automatic finish_run(input string nm);
      int g, bad;
      res_t r;
      g = 0; bad = 0;
      while (done !== 1'b1 && g < TO_TB + 100) begin
         if (load_ready !== 1'b0 || mem_we !== 1'b0) bad++;
         @(negedge clk1);
         g++;
      end
      r = res_q.pop_front();
      checks++;
      if (done !== 1'b1) begin
         errs++;
         $display("FAIL %s_done: done %b, want 1 within bound", nm, done);
      end
      checks++;
      if (pass !== r.p) begin
         errs++;
         $display("FAIL %s_pass: got %b want %b", nm, pass, r.p);
      end
      checks++;
      if (timed_out !== r.t) begin
         errs++;
         $display("FAIL %s_timed_out: got %b want %b", nm, timed_out, r.t);
      end
      checks++;
      if (cycles !== r.c) begin
         errs++;
         $display("FAIL %s_cycles: got %0d want %0d", nm, cycles, r.c);
      end
      checks++;
      if (cpu_rst !== 1'b1 || busy !== 1'b0) begin
         errs++;
         $display("FAIL %s_idle: cpu_rst %b busy %b, want 1 0", nm, cpu_rst, busy);
      end
      checks++;
      if (bad != 0) begin
         errs++;
         $display("FAIL %s_run_quiet: %0d cycles with ready/write, want 0", nm, bad);
      end
      @(negedge clk1);
      checks++;
      if (done !== 1'b0) begin
         errs++;
         $display("FAIL %s_done_pulse: done %b on second cycle, want 0", nm, done);
      end
   endtask

   task automatic run_seq(input logic [9:0] ca, input logic [31:0] ce, input logic ep,
                          input logic et, input int ec, input int hc, input string nm);
      res_t r;
      halt_cycle = hc;
      r.p = ep; r.t = et; r.c = 16'(ec);
      res_q.push_back(r);
      do_start(ca, ce);
      load_image();
      finish_run(nm);
   endtask

   task automatic add_program();
      img = {};
      img.push_back('{10'd0, 32'h2001_000A});   // ADDI R1,R0,10
      img.push_back('{10'd1, 32'h2002_0014});   // ADDI R2,R0,20
      img.push_back('{10'd2, 32'h2003_0019});   // ADDI R3,R0,25
      img.push_back('{10'd3, 32'h0022_2020});   // ADD  R4,R1,R2
      img.push_back('{10'd4, 32'h0083_2820});   // ADD  R5,R4,R3
      img.push_back('{10'd5, 32'hAC05_0064});   // SW   R5,100(R0)
      img.push_back('{10'd6, 32'hFC00_0000});   // HLT
      img.push_back('{10'd7, 32'h0});
      img.push_back('{10'd8, 32'h0});
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
      load_addr = '0; load_data = '0; chk_addr = '0; chk_expected = '0;
      repeat (3) @(negedge clk1);
      checks++;
      if ({load_ready, mem_we, cpu_rst, busy, done, pass, timed_out} !== 7'b0010000) begin
         errs++;
         $display("FAIL reset_flags: ready/we/rst/busy/done/pass/to %b, want 0010000",
                  {load_ready, mem_we, cpu_rst, busy, done, pass, timed_out});
      end
      checks++;
      if (mem_addr !== 10'h0 || mem_wdata !== 32'h0 || cycles !== 16'h0) begin
         errs++;
         $display("FAIL reset_values: addr %0d wdata %h cycles %0d, want 0 0 0",
                  mem_addr, mem_wdata, cycles);
      end
      reset = 1'b0;
      repeat (2) @(negedge clk1);
      checks++;
      if (load_ready !== 1'b0 || busy !== 1'b0) begin
         errs++;
         $display("FAIL idle_after_reset: ready %b busy %b, want 0 0", load_ready, busy);
      end
   endtask

   task automatic test_add_program();
      add_program();
      run_seq(10'd100, 32'd55, 1'b1, 1'b0, 40, 40, "add");
   endtask

   task automatic test_load_store();
      img = {};
      img.push_back('{10'd0, 32'h8C01_0078});   // LW   R1,120(R0)
      img.push_back('{10'd1, 32'h2022_002D});   // ADDI R2,R1,45
      img.push_back('{10'd2, 32'hAC02_0079});   // SW   R2,121(R0)
      img.push_back('{10'd3, 32'hFC00_0000});   // HLT
      img.push_back('{10'd120, 32'd85});
      run_seq(10'd121, 32'd130, 1'b1, 1'b0, 12, 12, "ldst_ok");
      run_seq(10'd121, 32'd131, 1'b0, 1'b0, 12, 12, "ldst_bad");
   endtask

   task automatic test_timeout();
      img = {};
      img.push_back('{10'd0, 32'h0});
      run_seq(10'd0, 32'h0, 1'b0, 1'b1, TO_TB, 100000, "timeout");
      img.push_back('{10'd1, 32'hFC00_0000});
      // Halt lands on the very cycle the count would reach TIMEOUT.
      run_seq(10'd1, 32'hFC00_0000, 1'b1, 1'b0, TO_TB - 1, TO_TB - 1, "halt_race");
      run_seq(10'd1, 32'hFC00_0000, 1'b0, 1'b1, TO_TB, TO_TB, "halt_late");
   endtask

   task automatic test_clear();
      img = {};
      img.push_back('{10'd0, 32'hFC00_0000});
      img.push_back('{10'd500, 32'hFFFF_FFFF});
      run_seq(10'd500, 32'hFFFF_FFFF, 1'b1, 1'b0, 3, 3, "clr_pre");
      img = {};
      img.push_back('{10'd0, 32'hFC00_0000});
      run_seq(10'd500, CLR_VAL, 1'b1, 1'b0, 3, 3, "clr_post");
      checks++;
      if (mem[500] !== CLR_VAL) begin
         errs++;
         $display("FAIL clear_word500: got %h want %h", mem[500], CLR_VAL);
      end
   endtask

   task automatic test_load_gaps();
      wr_t w[8];
      int  bad;
      img = {};
      img.push_back('{10'd0, 32'hFC00_0000});
      for (int i = 0; i < 8; i++) begin
         w[i].a = 10'(700 + 37 * i);
         w[i].d = $urandom();
         img.push_back(w[i]);
      end
      run_seq(w[3].a, w[3].d, 1'b1, 1'b0, 5, 5, "gaps");
      bad = 0;
      for (int i = 0; i < 8; i++) if (mem[w[i].a] !== w[i].d) bad++;
      checks++;
      if (bad != 0) begin
         errs++;
         $display("FAIL gaps_contents: %0d words wrong, want 0", bad);
      end
   endtask

   task automatic test_reset_mid_run();
      halt_cycle = 40;
      add_program();
      do_start(10'd100, 32'd55);
      load_image();
      repeat (12) @(negedge clk1);
      checks++;
      if (cycles !== 16'd12 || cpu_rst !== 1'b0) begin
         errs++;
         $display("FAIL midrun_progress: cycles %0d cpu_rst %b, want 12 0", cycles, cpu_rst);
      end
      reset = 1'b1;
      @(negedge clk1);
      reset = 1'b0;
      checks++;
      if (busy !== 1'b0 || cycles !== 16'd0 || cpu_rst !== 1'b1 || done !== 1'b0) begin
         errs++;
         $display("FAIL midrun_reset: busy %b cycles %0d cpu_rst %b done %b, want 0 0 1 0",
                  busy, cycles, cpu_rst, done);
      end
      run_seq(10'd100, 32'd55, 1'b1, 1'b0, 40, 40, "after_reset");
   endtask

   initial begin
      test_reset();
      test_add_program();
      test_load_store();
      test_timeout();
      test_clear();
      test_load_gaps();
      test_reset_mid_run();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
      $finish;
   end

endmodule
